// File: rtl/div32_u_seq.sv
// Iterative unsigned divider, restoring radix-2, one quotient bit per clock (LO = quotient, HI = remainder).
// Optional macro DIV32_EARLY_OUT_EN: finish in one cycle when A < B (non-zero B).
module div32_u_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO,
    output logic                  DIV_BY_ZERO
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [1:0]            state;
    logic                  fin_pend;
    logic [DATA_WIDTH-1:0] dvd;
    logic [DATA_WIDTH-1:0] dsr;
    logic [DATA_WIDTH-1:0] rem;
    logic [CNT_W-1:0]      count;
    logic                  accept;
    logic                  short_op;
    logic [DATA_WIDTH:0]   step;

    // One restoring step on a 33-bit trial remainder; returns {quotient bit, new remainder}.
    function automatic logic [DATA_WIDTH:0] div_step(
        input logic [DATA_WIDTH-1:0] r,
        input logic                  next_bit,
        input logic [DATA_WIDTH-1:0] d
    );
        logic [DATA_WIDTH:0] r_sh;
        logic [DATA_WIDTH:0] d_ext;
        r_sh  = {r, next_bit};
        d_ext = {1'b0, d};
        if (r_sh >= d_ext)
            div_step = {1'b1, DATA_WIDTH'(r_sh - d_ext)};
        else
            div_step = {1'b0, r_sh[DATA_WIDTH-1:0]};
    endfunction

    assign step   = div_step(rem, dvd[DATA_WIDTH-1], dsr);
    assign accept = START && ((state == S_IDLE) || ((state == S_FIN) && !fin_pend));

`ifdef DIV32_EARLY_OUT_EN
    assign short_op = (B == '0) || (A < B);
`else
    assign short_op = (B == '0);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            fin_pend    <= 1'b0;
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            count       <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            HI          <= '0;
            LO          <= '0;
            DIV_BY_ZERO <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    rem   <= step[DATA_WIDTH-1:0];
                    dvd   <= {dvd[DATA_WIDTH-2:0], step[DATA_WIDTH]};
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        state       <= S_FIN;
                        BUSY        <= 1'b0;
                        DONE        <= 1'b1;
                        HI          <= step[DATA_WIDTH-1:0];
                        LO          <= {dvd[DATA_WIDTH-2:0], step[DATA_WIDTH]};
                        DIV_BY_ZERO <= 1'b0;
                    end
                end
                S_FIN: begin
                    // Short operations park here one cycle so results register at t0+1.
                    if (fin_pend) begin
                        fin_pend    <= 1'b0;
                        BUSY        <= 1'b0;
                        DONE        <= 1'b1;
                        HI          <= dvd;
                        LO          <= (dsr == '0) ? '1 : '0;
                        DIV_BY_ZERO <= (dsr == '0);
                    end else begin
                        DONE  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    DONE  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase

            if (accept) begin
                dvd      <= A;
                dsr      <= B;
                rem      <= '0;
                count    <= CNT_INIT;
                BUSY     <= 1'b1;
                DONE     <= 1'b0;
                fin_pend <= short_op;
                state    <= short_op ? S_FIN : S_RUN;
            end
        end
    end

endmodule
